btn_event_ctrl: RTL

BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

---
 rtl/btn_pkg.sv | 17 +
 rtl/btn_timer.sv | 31 +++
 rtl/btn_event_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and event codes for the button gesture controller.
package btn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS1,
        ST_WAIT2,
        ST_PRESS2,
        ST_HOLD
    } btn_state_e;

    localparam logic [1:0] EVT_NONE   = 2'b00;
    localparam logic [1:0] EVT_SHORT  = 2'b01;
    localparam logic [1:0] EVT_LONG   = 2'b10;
    localparam logic [1:0] EVT_DOUBLE = 2'b11;

endpackage

// File: rtl/btn_timer.sv
// Gesture timing counter: synchronous clear, count enable, and terminal-count
// compares for the long-press and double-click windows.
module btn_timer #(
    parameter int LONG_CYC   = 100_000_000,
    parameter int DCLICK_CYC = 30_000_000,
    parameter int CNT_W      = 27
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_long_hit,
    output logic o_dclick_hit
);

    logic [CNT_W-1:0] r_cnt;

    // Saturating guard keeps the counter from wrapping even if enable is held.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_long_hit   = (r_cnt == CNT_W'(LONG_CYC - 1));
    assign o_dclick_hit = (r_cnt == CNT_W'(DCLICK_CYC - 1));

endmodule

// File: rtl/btn_event_ctrl.sv
// Classifies debounced button activity into SHORT / LONG / DOUBLE events and
// holds one event in a ready/valid output register with a sticky drop flag.
module btn_event_ctrl
    import btn_pkg::*;
#(
    parameter int LONG_CYC   = 100_000_000,
    parameter int DCLICK_CYC = 30_000_000,
    parameter int CNT_W      = 27
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       db_level,
    input  logic       db_edge,
    input  logic       evt_ready,
    input  logic       ovf_clr,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    output logic       evt_ovf,
    output logic       busy
);

    if (!((DCLICK_CYC >= 2) && (DCLICK_CYC < LONG_CYC) &&
          (longint'(LONG_CYC) < (longint'(1) << CNT_W)))) begin : g_param_chk
        $error("btn_event_ctrl: need 2 <= DCLICK_CYC < LONG_CYC < 2**CNT_W");
    end

    btn_state_e r_state;
    logic       r_busy;
    logic       r_valid;
    logic [1:0] r_code;
    logic       r_ovf;

    logic       w_press, w_rel;
    logic       w_clr, w_en;
    logic       w_long_hit, w_dclick_hit;
    logic       w_emit, w_drop;
    logic [1:0] w_code;

    assign w_press = db_edge & db_level;
    assign w_rel   = db_edge & ~db_level;

    // IDLE clears every cycle so a fresh press always starts from zero.
    assign w_clr = (r_state == ST_IDLE) ||
                   ((r_state == ST_PRESS1) && w_rel) ||
                   ((r_state == ST_WAIT2) && w_press);
    assign w_en  = (r_state == ST_PRESS1) || (r_state == ST_WAIT2) ||
                   (r_state == ST_PRESS2);

    btn_timer #(
        .LONG_CYC   (LONG_CYC),
        .DCLICK_CYC (DCLICK_CYC),
        .CNT_W      (CNT_W)
    ) u_timer (
        .i_clk        (clk),
        .i_rst_n      (reset_n),
        .i_clr        (w_clr),
        .i_en         (w_en),
        .o_long_hit   (w_long_hit),
        .o_dclick_hit (w_dclick_hit)
    );

    always_comb begin
        w_emit = 1'b0;
        w_code = EVT_NONE;
        case (r_state)
            ST_PRESS1: if (!w_rel && w_long_hit) begin
                w_emit = 1'b1;
                w_code = EVT_LONG;
            end
            ST_WAIT2: if (!w_press && w_dclick_hit) begin
                w_emit = 1'b1;
                w_code = EVT_SHORT;
            end
            ST_PRESS2: if (w_rel || w_long_hit) begin
                w_emit = 1'b1;
                w_code = EVT_DOUBLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_press) begin
                    r_state <= ST_PRESS1;
                    r_busy  <= 1'b1;
                end
                ST_PRESS1: begin
                    if (w_rel)
                        r_state <= ST_WAIT2;
                    else if (w_long_hit)
                        r_state <= ST_HOLD;
                end
                ST_WAIT2: begin
                    if (w_press)
                        r_state <= ST_PRESS2;
                    else if (w_dclick_hit) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_PRESS2: begin
                    if (w_rel) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_long_hit)
                        r_state <= ST_HOLD;
                end
                ST_HOLD: if (w_rel) begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // A new event only lands if the slot is empty or being drained this cycle.
    assign w_drop = w_emit & r_valid & ~evt_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_code  <= EVT_NONE;
            r_ovf   <= 1'b0;
        end else begin
            if (w_emit && (!r_valid || evt_ready)) begin
                r_valid <= 1'b1;
                r_code  <= w_code;
            end else if (r_valid && evt_ready) begin
                r_valid <= 1'b0;
                r_code  <= EVT_NONE;
            end
            if (w_drop)
                r_ovf <= 1'b1;
            else if (ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    assign evt_valid = r_valid;
    assign evt_code  = r_code;
    assign evt_ovf   = r_ovf;
    assign busy      = r_busy;

endmodule
